// File: rtl/readout_buf_ctrl.sv
// Round-robin two-channel write arbiter and circular-FIFO sequencer for a
// synchronous-write / combinational-read register-file RAM, drained through a registered valid/ready stage.
module readout_buf_ctrl #(
   parameter int DATA_WIDTH = 24,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  ch0_req,
   input  logic [DATA_WIDTH-1:0] ch0_data,
   output logic                  ch0_gnt,
   input  logic                  ch1_req,
   input  logic [DATA_WIDTH-1:0] ch1_data,
   output logic                  ch1_gnt,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  full,
   output logic                  empty,
   output logic                  ram_cs_n,
   output logic                  ram_wr_n,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [ADDR_WIDTH:0]   mcnt_q, mcnt_d;
   logic                  prio_q, prio_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   logic full_s, gnt0_s, gnt1_s, wr_s, load_s;

   // rst gates the grant so an in-flight write aborts the instant reset rises
   assign full_s = (mcnt_q == DEPTH_C);
   assign wr_s   = gnt0_s | gnt1_s;
   assign load_s = (mcnt_q != {(ADDR_WIDTH+1){1'b0}}) & (~out_valid_q | out_ready) & ~flush;

   // Grant arbitration: single requester wins outright, prio breaks ties
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (!rst && !flush && !full_s) begin
         if (ch0_req && ch1_req) begin
            gnt0_s = ~prio_q;
            gnt1_s = prio_q;
         end else begin
            gnt0_s = ch0_req;
            gnt1_s = ch1_req;
         end
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Next-state for pointers, count, priority and the output stage
   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      mcnt_d      = mcnt_q;
      prio_d      = prio_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (flush) begin
         wptr_d      = {ADDR_WIDTH{1'b0}};
         rptr_d      = {ADDR_WIDTH{1'b0}};
         mcnt_d      = {(ADDR_WIDTH+1){1'b0}};
         out_valid_d = 1'b0;
      end else begin
         if (wr_s) begin
            wptr_d = wptr_q + PTR_ONE;
         end else begin
            wptr_d = wptr_q;
         end
         if (load_s) begin
            rptr_d      = rptr_q + PTR_ONE;
            out_valid_d = 1'b1;
            out_data_d  = ram_data_out;
         end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = out_valid_q;
         end
         mcnt_d = mcnt_q + (ADDR_WIDTH+1)'(wr_s) - (ADDR_WIDTH+1)'(load_s);
      end
      if (gnt0_s) begin
         prio_d = 1'b1;
      end else if (gnt1_s) begin
         prio_d = 1'b0;
      end else begin
         prio_d = prio_q;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q      <= {ADDR_WIDTH{1'b0}};
         rptr_q      <= {ADDR_WIDTH{1'b0}};
         mcnt_q      <= {(ADDR_WIDTH+1){1'b0}};
         prio_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= {DATA_WIDTH{1'b0}};
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         mcnt_q      <= mcnt_d;
         prio_q      <= prio_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign ch0_gnt     = gnt0_s;
   assign ch1_gnt     = gnt1_s;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign level       = mcnt_q + (ADDR_WIDTH+1)'(out_valid_q);
   assign full        = full_s;
   assign empty       = (level == {(ADDR_WIDTH+1){1'b0}});
   assign ram_cs_n    = ~wr_s;
   assign ram_wr_n    = ~wr_s;
   assign ram_wr_addr = wptr_q;
   assign ram_rd_addr = rptr_q;
   assign ram_data_in = gnt1_s ? ch1_data : ch0_data;

endmodule

// File: tb/tb_readout_buf_ctrl.sv
// Directed bench for readout_buf_ctrl with a behavioural register-file RAM.
module tb_readout_buf_ctrl;
   localparam int DW = 24;
   localparam int DEPTH = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, flush, ch0_req, ch1_req, ch0_gnt, ch1_gnt;
   logic [DW-1:0] ch0_data, ch1_data, out_data, ram_data_in, ram_data_out;
   logic          out_valid, out_ready, full, empty, ram_cs_n, ram_wr_n;
   logic [AW:0]   level;
   logic [AW-1:0] ram_wr_addr, ram_rd_addr;

   readout_buf_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .ch0_req(ch0_req), .ch0_data(ch0_data), .ch0_gnt(ch0_gnt),
      .ch1_req(ch1_req), .ch1_data(ch1_data), .ch1_gnt(ch1_gnt),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level), .full(full), .empty(empty),
      .ram_cs_n(ram_cs_n), .ram_wr_n(ram_wr_n),
      .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (!ram_cs_n && !ram_wr_n) mem[ram_wr_addr] <= ram_data_in;
   end
   assign ram_data_out = mem[ram_rd_addr];

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] got_q[$];
   logic          s_g0, s_g1, s_wr_n, s_cs_n, s_xfer;
   logic [AW-1:0] s_wa;
   logic [DW-1:0] s_din;
   int            max_lvl;

   // one clock: snapshot comb outputs mid-cycle, record transfers, return at posedge+1
   task automatic tick();
      @(negedge clk);
      s_g0 = ch0_gnt; s_g1 = ch1_gnt; s_wr_n = ram_wr_n; s_cs_n = ram_cs_n;
      s_wa = ram_wr_addr; s_din = ram_data_in;
      s_xfer = out_valid && out_ready;
      if (s_xfer) got_q.push_back(out_data);
      if (int'(level) > max_lvl) max_lvl = int'(level);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; ch0_req = 1'b0; ch1_req = 1'b0; out_ready = 1'b0;
      ch0_data = 24'h000000; ch1_data = 24'h000000;
      got_q.delete(); max_lvl = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      ch0_req = 1'b0; ch1_req = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 80 && empty !== 1'b1; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; ch0_req = 1'b1; ch1_req = 1'b0; out_ready = 1'b0;
      ch0_data = 24'h123456; ch1_data = 24'h000000;
      #2;
      checks++; if (ch0_gnt !== 1'b0 || ch1_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b want 00", ch0_gnt, ch1_gnt); end
      checks++; if (ram_wr_n !== 1'b1 || ram_cs_n !== 1'b1) begin errors++; $display("FAIL reset_ram_ctl: wr_n=%b cs_n=%b want 1 1", ram_wr_n, ram_cs_n); end
      checks++; if (level !== 6'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_status: level=%0d empty=%b full=%b want 0 1 0", level, empty, full); end
      checks++; if (out_valid !== 1'b0 || out_data !== 24'h000000) begin errors++; $display("FAIL reset_out: valid=%b data=%h want 0 000000", out_valid, out_data); end
      checks++; if (ram_wr_addr !== 5'd0 || ram_rd_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: wa=%0d ra=%0d want 0 0", ram_wr_addr, ram_rd_addr); end
      ch0_req = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      ch0_req = 1'b1; ch0_data = 24'hA5A5A5; out_ready = 1'b1;
      tick();
      ch0_req = 1'b0;
      checks++; if (s_g0 !== 1'b1 || s_g1 !== 1'b0) begin errors++; $display("FAIL single_gnt: got %b%b want 10", s_g0, s_g1); end
      checks++; if (s_wa !== 5'd0 || s_wr_n !== 1'b0 || s_cs_n !== 1'b0 || s_din !== 24'hA5A5A5) begin errors++; $display("FAIL single_write: wa=%0d wr_n=%b cs_n=%b din=%h want 0 0 0 a5a5a5", s_wa, s_wr_n, s_cs_n, s_din); end
      checks++; if (out_valid !== 1'b0 || level !== 6'd1 || empty !== 1'b0) begin errors++; $display("FAIL single_after_write: valid=%b level=%0d empty=%b want 0 1 0", out_valid, level, empty); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 24'hA5A5A5) begin errors++; $display("FAIL single_out: valid=%b data=%h want 1 a5a5a5", out_valid, out_data); end
      tick();
      checks++; if (out_valid !== 1'b0 || level !== 6'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_drained: valid=%b level=%0d empty=%b want 0 0 1", out_valid, level, empty); end
   endtask

   task automatic test_round_robin();
      int n0, n1, exp_ch;
      logic [DW-1:0] w;
      do_reset();
      n0 = 0; n1 = 0; exp_ch = 0;
      out_ready = 1'b1; ch0_req = 1'b1; ch1_req = 1'b1;
      ch0_data = 24'h100000; ch1_data = 24'h200000;
      for (int c = 0; c < 20; c++) begin
         tick();
         checks++; if (s_g0 !== (exp_ch == 0) || s_g1 !== (exp_ch == 1)) begin errors++; $display("FAIL rr_gnt cycle %0d: got %b%b want ch%0d", c, s_g0, s_g1, exp_ch); end
         exp_ch = 1 - exp_ch;
         if (s_g0) begin n0++; ch0_data = 24'h100000 + 24'(n0); end
         if (s_g1) begin n1++; ch1_data = 24'h200000 + 24'(n1); end
      end
      drain();
      checks++; if (got_q.size() !== 20) begin errors++; $display("FAIL rr_count: got %0d words want 20", got_q.size()); end
      for (int k = 0; k < got_q.size() && k < 20; k++) begin
         w = ((k % 2) == 0) ? (24'h100000 + 24'(k / 2)) : (24'h200000 + 24'(k / 2));
         checks++; if (got_q[k] !== w) begin errors++; $display("FAIL rr_order[%0d]: got %h want %h", k, got_q[k], w); end
      end
   endtask

   task automatic test_full();
      int n, bound;
      do_reset();
      n = 0; out_ready = 1'b0; ch1_req = 1'b1; ch1_data = 24'h300000;
      for (int c = 0; c < 45; c++) begin
         tick();
         if (s_g1) begin n++; ch1_data = 24'h300000 + 24'(n); end
      end
      checks++; if (n !== 33) begin errors++; $display("FAIL full_grants: got %0d want 33", n); end
      checks++; if (level !== 6'd33 || full !== 1'b1) begin errors++; $display("FAIL full_status: level=%0d full=%b want 33 1", level, full); end
      checks++; if (s_g1 !== 1'b0) begin errors++; $display("FAIL full_no_gnt: got %b want 0", s_g1); end
      out_ready = 1'b1;
      tick();
      if (s_g1) begin n++; ch1_data = 24'h300000 + 24'(n); end
      checks++; if (s_xfer !== 1'b1 || s_g1 !== 1'b0) begin errors++; $display("FAIL full_first_xfer: xfer=%b gnt=%b want 1 0", s_xfer, s_g1); end
      tick();
      if (s_g1) begin n++; ch1_data = 24'h300000 + 24'(n); end
      checks++; if (s_g1 !== 1'b1) begin errors++; $display("FAIL full_resume: gnt=%b want 1", s_g1); end
      bound = 40;
      while (n < 40 && bound > 0) begin
         tick();
         if (s_g1) begin n++; ch1_data = 24'h300000 + 24'(n); end
         bound--;
      end
      drain();
      checks++; if (got_q.size() !== 40) begin errors++; $display("FAIL full_count: got %0d words want 40", got_q.size()); end
      for (int k = 0; k < got_q.size() && k < 40; k++) begin
         checks++; if (got_q[k] !== 24'h300000 + 24'(k)) begin errors++; $display("FAIL full_order[%0d]: got %h want %h", k, got_q[k], 24'h300000 + 24'(k)); end
      end
   endtask

   task automatic test_wrap();
      int n;
      do_reset();
      n = 0; ch0_req = 1'b1; ch0_data = 24'h400000;
      for (int c = 0; c < 400 && n < 100; c++) begin
         out_ready = (c % 2) == 1;
         tick();
         if (s_g0) begin
            checks++; if (s_wa !== 5'(n)) begin errors++; $display("FAIL wrap_waddr word %0d: got %0d want %0d", n, s_wa, n % 32); end
            n++; ch0_data = 24'h400000 + 24'(n);
            if (n == 100) ch0_req = 1'b0;
         end
      end
      drain();
      checks++; if (got_q.size() !== 100) begin errors++; $display("FAIL wrap_count: got %0d words want 100", got_q.size()); end
      for (int k = 0; k < got_q.size() && k < 100; k++) begin
         checks++; if (got_q[k] !== 24'h400000 + 24'(k)) begin errors++; $display("FAIL wrap_order[%0d]: got %h want %h", k, got_q[k], 24'h400000 + 24'(k)); end
      end
      checks++; if (max_lvl !== 33) begin errors++; $display("FAIL wrap_max_level: got %0d want 33", max_lvl); end
      checks++; if (ram_rd_addr !== 5'd4 || ram_wr_addr !== 5'd4) begin errors++; $display("FAIL wrap_ptrs: ra=%0d wa=%0d want 4 4", ram_rd_addr, ram_wr_addr); end
   endtask

   task automatic test_flush();
      int n;
      do_reset();
      n = 0; out_ready = 1'b0; ch0_req = 1'b1; ch0_data = 24'h500000;
      for (int c = 0; c < 20 && n < 10; c++) begin
         tick();
         if (s_g0) begin n++; ch0_data = 24'h500000 + 24'(n); end
      end
      checks++; if (level !== 6'd10) begin errors++; $display("FAIL flush_pre_level: got %0d want 10", level); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (s_g0 !== 1'b0 || s_g1 !== 1'b0) begin errors++; $display("FAIL flush_gnt: got %b%b want 00", s_g0, s_g1); end
      checks++; if (level !== 6'd0 || out_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL flush_state: level=%0d valid=%b empty=%b want 0 0 1", level, out_valid, empty); end
      tick();
      ch0_req = 1'b0;
      checks++; if (s_g0 !== 1'b1 || s_wa !== 5'd0 || s_din !== 24'h50000A) begin errors++; $display("FAIL flush_next_write: gnt=%b wa=%0d din=%h want 1 0 50000a", s_g0, s_wa, s_din); end
   endtask

   task automatic test_async_reset();
      do_reset();
      out_ready = 1'b0; ch1_req = 1'b1; ch1_data = 24'h600000;
      tick(); tick(); tick();
      #2;
      checks++; if (ch1_gnt !== 1'b1 || ram_wr_n !== 1'b0) begin errors++; $display("FAIL arst_pre: gnt=%b wr_n=%b want 1 0", ch1_gnt, ram_wr_n); end
      rst = 1'b1;
      #1;
      checks++; if (ch1_gnt !== 1'b0 || ram_wr_n !== 1'b1 || ram_cs_n !== 1'b1) begin errors++; $display("FAIL arst_abort: gnt=%b wr_n=%b cs_n=%b want 0 1 1", ch1_gnt, ram_wr_n, ram_cs_n); end
      checks++; if (level !== 6'd0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 || out_data !== 24'h000000) begin errors++; $display("FAIL arst_status: level=%0d empty=%b full=%b valid=%b data=%h want 0 1 0 0 000000", level, empty, full, out_valid, out_data); end
      checks++; if (ram_wr_addr !== 5'd0 || ram_rd_addr !== 5'd0) begin errors++; $display("FAIL arst_addr: wa=%0d ra=%0d want 0 0", ram_wr_addr, ram_rd_addr); end
      ch1_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full();
      test_wrap();
      test_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
